// File: rtl/lc3_regfile_sb.sv
// lc3_regfile_sb
// Register file for the pipelined LC-3 core. It holds NUM_REGS registers of
// DATA_W bits and provides the following:
//   - two combinational read ports, with optional same-cycle write forwarding
//   - one general write port
//   - a dedicated link-register write port for JSR/JSRR/TRAP
//   - an NZP condition-code register and branch-condition evaluation
//   - a per-register pending-write scoreboard that stalls reads of
//     registers still waiting on a long-latency (load) result
//
// Ports:
//   clk, rst_n             clock (posedge) and asynchronous active-low reset
//   rd_addr_a/b            read port addresses
//   rd_data_a/b            read port data
//   wr_en/wr_addr/wr_data  general write; wr_data is also the cc source
//   link_en/link_data      write of the return address into LINK_REG
//   cc_en                  load NZP from wr_data on this edge
//   nzp                    current condition codes {N,Z,P}
//   br_nzp/br_taken        branch mask from the instruction, and its result
//   sb_set/sb_addr         mark a register as having a pending write
//   stall_a/stall_b        the read source of port A/B is still pending
module lc3_regfile_sb #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int LINK_REG = 7,
    parameter bit BYPASS   = 1'b1,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     rd_addr_a,
    input  logic [AW-1:0]     rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              link_en,
    input  logic [DATA_W-1:0] link_data,
    input  logic              cc_en,
    output logic [2:0]        nzp,
    input  logic [2:0]        br_nzp,
    output logic              br_taken,
    input  logic              sb_set,
    input  logic [AW-1:0]     sb_addr,
    output logic              stall_a,
    output logic              stall_b
);

    localparam logic [AW-1:0] LINK_IDX = AW'(LINK_REG);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0] pending;

    logic a_valid, b_valid;
    logic a_link_hit, b_link_hit;
    logic a_wr_hit, b_wr_hit;

    // When NUM_REGS is not a power of two, some addresses have no register.
    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < NUM_REGS;
    endfunction

    // Register array. The link write comes after the general write, so on a
    // collision at LINK_REG the return address is the value that lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr_en && in_range(wr_addr)) begin
                regs[wr_addr] <= wr_data;
            end
            if (link_en) begin
                regs[LINK_REG] <= link_data;
            end
        end
    end

    // Scoreboard. Any commit to a register clears its pending bit. A set in
    // the same edge is applied last, so it wins, because a newly issued load
    // supersedes the older result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            if (wr_en && in_range(wr_addr)) begin
                pending[wr_addr] <= 1'b0;
            end
            if (link_en) begin
                pending[LINK_REG] <= 1'b0;
            end
            if (sb_set && in_range(sb_addr)) begin
                pending[sb_addr] <= 1'b1;
            end
        end
    end

    // Condition codes. These are derived from wr_data whenever cc_en is set,
    // regardless of whether the write itself is enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nzp <= 3'b010;
        end else if (cc_en) begin
            nzp[2] <= wr_data[DATA_W-1];
            nzp[1] <= (wr_data == '0);
            nzp[0] <= !wr_data[DATA_W-1] && (wr_data != '0);
        end
    end

    // Forwarding hit detection. The link port has priority over the general
    // write port, which matches the commit order of the array.
    always_comb begin
        a_valid    = in_range(rd_addr_a);
        b_valid    = in_range(rd_addr_b);
        a_link_hit = BYPASS && link_en && (rd_addr_a == LINK_IDX);
        b_link_hit = BYPASS && link_en && (rd_addr_b == LINK_IDX);
        a_wr_hit   = BYPASS && wr_en && (wr_addr == rd_addr_a);
        b_wr_hit   = BYPASS && wr_en && (wr_addr == rd_addr_b);
    end

    always_comb begin
        rd_data_a = '0;
        if (a_valid) begin
            if (a_link_hit) begin
                rd_data_a = link_data;
            end else if (a_wr_hit) begin
                rd_data_a = wr_data;
            end else begin
                rd_data_a = regs[rd_addr_a];
            end
        end
    end

    always_comb begin
        rd_data_b = '0;
        if (b_valid) begin
            if (b_link_hit) begin
                rd_data_b = link_data;
            end else if (b_wr_hit) begin
                rd_data_b = wr_data;
            end else begin
                rd_data_b = regs[rd_addr_b];
            end
        end
    end

    // A forwarded write satisfies the pending read in the same cycle, so the
    // stall is released. sb_set deliberately has no path into the stall
    // outputs.
    always_comb begin
        stall_a = 1'b0;
        stall_b = 1'b0;
        if (a_valid) begin
            stall_a = pending[rd_addr_a] && !(a_link_hit || a_wr_hit);
        end
        if (b_valid) begin
            stall_b = pending[rd_addr_b] && !(b_link_hit || b_wr_hit);
        end
    end

    assign br_taken = |(br_nzp & nzp);

endmodule

// File: tb/tb_lc3_regfile_sb.sv
// tb_lc3_regfile_sb
// Scoreboard-checked bench for lc3_regfile_sb. There are three instances:
//   u0  default parameters, with forwarding
//   u1  same parameters with forwarding disabled
//   u2  32-bit data, 6 registers, link register 5
// u0 and u1 share their inputs. The stimulus drives each cycle's inputs
// shortly after posedge and queues the hand-computed responses. The monitor
// drains the queue on the following negedge and compares the responses
// against the instances.
module tb_lc3_regfile_sb;

    logic clk;
    logic rst_n;

    logic [2:0]  rd_addr_a, rd_addr_b, wr_addr, sb_addr, br_nzp;
    logic        wr_en, link_en, cc_en, sb_set;
    logic [15:0] wr_data, link_data;
    logic [15:0] rd_data_a_u0, rd_data_b_u0, rd_data_a_u1, rd_data_b_u1;
    logic [2:0]  nzp_u0, nzp_u1;
    logic        br_taken_u0, br_taken_u1;
    logic        stall_a_u0, stall_b_u0, stall_a_u1, stall_b_u1;

    logic [2:0]  p_rd_addr_a, p_rd_addr_b, p_wr_addr, p_sb_addr, p_br_nzp;
    logic        p_wr_en, p_link_en, p_cc_en, p_sb_set;
    logic [31:0] p_wr_data, p_link_data;
    logic [31:0] p_rd_data_a, p_rd_data_b;
    logic [2:0]  p_nzp;
    logic        p_br_taken, p_stall_a, p_stall_b;

    typedef struct {
        string       name;
        int          unit;
        int          field;
        logic [31:0] expv;
    } exp_t;

    exp_t exp_q[$];
    int checks;
    int failures;

    lc3_regfile_sb u0 (
        .clk(clk), .rst_n(rst_n),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a_u0), .rd_data_b(rd_data_b_u0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .link_en(link_en), .link_data(link_data),
        .cc_en(cc_en), .nzp(nzp_u0),
        .br_nzp(br_nzp), .br_taken(br_taken_u0),
        .sb_set(sb_set), .sb_addr(sb_addr),
        .stall_a(stall_a_u0), .stall_b(stall_b_u0)
    );

    lc3_regfile_sb #(.BYPASS(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a_u1), .rd_data_b(rd_data_b_u1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .link_en(link_en), .link_data(link_data),
        .cc_en(cc_en), .nzp(nzp_u1),
        .br_nzp(br_nzp), .br_taken(br_taken_u1),
        .sb_set(sb_set), .sb_addr(sb_addr),
        .stall_a(stall_a_u1), .stall_b(stall_b_u1)
    );

    lc3_regfile_sb #(.DATA_W(32), .NUM_REGS(6), .LINK_REG(5)) u2 (
        .clk(clk), .rst_n(rst_n),
        .rd_addr_a(p_rd_addr_a), .rd_addr_b(p_rd_addr_b),
        .rd_data_a(p_rd_data_a), .rd_data_b(p_rd_data_b),
        .wr_en(p_wr_en), .wr_addr(p_wr_addr), .wr_data(p_wr_data),
        .link_en(p_link_en), .link_data(p_link_data),
        .cc_en(p_cc_en), .nzp(p_nzp),
        .br_nzp(p_br_nzp), .br_taken(p_br_taken),
        .sb_set(p_sb_set), .sb_addr(p_sb_addr),
        .stall_a(p_stall_a), .stall_b(p_stall_b)
    );

    // Free-running clock. The first posedge occurs at t=5.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Field codes: 0 rd_data_a, 1 rd_data_b, 2 nzp, 3 br_taken, 4 stall_a,
    // 5 stall_b.
    function automatic logic [31:0] get_actual(input int unit, input int field);
        logic [31:0] v;
        v = '0;
        case (unit)
            0: case (field)
                0: v = 32'(rd_data_a_u0);
                1: v = 32'(rd_data_b_u0);
                2: v = 32'(nzp_u0);
                3: v = 32'(br_taken_u0);
                4: v = 32'(stall_a_u0);
                default: v = 32'(stall_b_u0);
            endcase
            1: case (field)
                0: v = 32'(rd_data_a_u1);
                1: v = 32'(rd_data_b_u1);
                2: v = 32'(nzp_u1);
                3: v = 32'(br_taken_u1);
                4: v = 32'(stall_a_u1);
                default: v = 32'(stall_b_u1);
            endcase
            default: case (field)
                0: v = p_rd_data_a;
                1: v = p_rd_data_b;
                2: v = 32'(p_nzp);
                3: v = 32'(p_br_taken);
                4: v = 32'(p_stall_a);
                default: v = 32'(p_stall_b);
            endcase
        endcase
        return v;
    endfunction

    task automatic checkOutput(input exp_t e);
        logic [31:0] act;
        act = get_actual(e.unit, e.field);
        checks++;
        if (act !== e.expv) begin
            failures++;
            $display("[TB] FAIL %s unit=%0d field=%0d got=%h expected=%h",
                     e.name, e.unit, e.field, act, e.expv);
        end
    endtask

    // Monitor: on each negedge, every response queued for this cycle is
    // popped and compared.
    always @(negedge clk) begin
        while (exp_q.size() != 0) begin
            checkOutput(exp_q.pop_front());
        end
    end

    task automatic push_expect(input string name, input int unit,
                               input int field, input logic [31:0] v);
        exp_t e;
        e.name  = name;
        e.unit  = unit;
        e.field = field;
        e.expv  = v;
        exp_q.push_back(e);
    endtask

    // Advances to the next cycle and returns every data input to idle. The
    // caller then overrides the inputs for this cycle.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        rd_addr_a = '0; rd_addr_b = '0; wr_addr = '0; sb_addr = '0;
        br_nzp = '0; wr_en = 1'b0; link_en = 1'b0; cc_en = 1'b0;
        sb_set = 1'b0; wr_data = '0; link_data = '0;
        p_rd_addr_a = '0; p_rd_addr_b = '0; p_wr_addr = '0; p_sb_addr = '0;
        p_br_nzp = '0; p_wr_en = 1'b0; p_link_en = 1'b0; p_cc_en = 1'b0;
        p_sb_set = 1'b0; p_wr_data = '0; p_link_data = '0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;

        // Outputs while reset is held.
        applyStimulus();
        br_nzp = 3'b010; rd_addr_a = 3'd3; rd_addr_b = 3'd5;
        push_expect("reset_rd_a", 0, 0, 32'h0);
        push_expect("reset_nzp", 0, 2, 32'h2);
        push_expect("reset_br", 0, 3, 32'h1);
        push_expect("reset_stall_b", 0, 5, 32'h0);
        push_expect("reset_nzp_nb", 1, 2, 32'h2);
        push_expect("reset_nzp_p", 2, 2, 32'h2);
        applyStimulus();
        rst_n = 1'b1;

        // Reset asserted in the middle of a write, a cc load and an sb_set.
        applyStimulus();
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h1234;
        cc_en = 1'b1; sb_set = 1'b1; sb_addr = 3'd5;
        #2 rst_n = 1'b0;
        applyStimulus();
        applyStimulus();
        rst_n = 1'b1;
        rd_addr_a = 3'd3; rd_addr_b = 3'd5; br_nzp = 3'b010;
        push_expect("midrst_r3", 0, 0, 32'h0);
        push_expect("midrst_r3_nb", 1, 0, 32'h0);
        push_expect("midrst_nzp", 0, 2, 32'h2);
        push_expect("midrst_br", 0, 3, 32'h1);
        push_expect("midrst_stall_b", 0, 5, 32'h0);
        push_expect("midrst_stall_b_nb", 1, 5, 32'h0);

        // Write with a same-cycle read of the same register.
        applyStimulus();
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hBEEF; rd_addr_a = 3'd2;
        push_expect("byp_r2", 0, 0, 32'hBEEF);
        push_expect("nobyp_r2_old", 1, 0, 32'h0);
        applyStimulus();
        rd_addr_a = 3'd2;
        push_expect("byp_r2_next", 0, 0, 32'hBEEF);
        push_expect("nobyp_r2_next", 1, 0, 32'hBEEF);

        // Condition codes and branch evaluation.
        applyStimulus();
        cc_en = 1'b1; wr_data = 16'h8000; br_nzp = 3'b011;
        push_expect("br_uses_old_cc", 0, 3, 32'h1);
        applyStimulus();
        cc_en = 1'b1; wr_data = 16'h0000; br_nzp = 3'b011;
        push_expect("cc_neg", 0, 2, 32'h4);
        push_expect("cc_neg_nb", 1, 2, 32'h4);
        push_expect("br_neg", 0, 3, 32'h0);
        applyStimulus();
        cc_en = 1'b1; wr_data = 16'h0001; br_nzp = 3'b011;
        push_expect("cc_zero", 0, 2, 32'h2);
        push_expect("br_zero", 0, 3, 32'h1);
        applyStimulus();
        br_nzp = 3'b011;
        push_expect("cc_pos", 0, 2, 32'h1);
        push_expect("br_pos", 0, 3, 32'h1);
        applyStimulus();
        br_nzp = 3'b000;
        push_expect("br_mask_000", 0, 3, 32'h0);
        applyStimulus();
        br_nzp = 3'b111;
        push_expect("br_mask_111", 0, 3, 32'h1);
        push_expect("cc_hold", 0, 2, 32'h1);

        // A general write and a link write to LINK_REG on the same edge.
        applyStimulus();
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'h1111;
        link_en = 1'b1; link_data = 16'h3001; rd_addr_a = 3'd7;
        push_expect("coll_byp", 0, 0, 32'h3001);
        push_expect("coll_nobyp_old", 1, 0, 32'h0);
        applyStimulus();
        rd_addr_a = 3'd7;
        push_expect("coll_r7", 0, 0, 32'h3001);
        push_expect("coll_r7_nb", 1, 0, 32'h3001);
        push_expect("link_keeps_cc", 0, 2, 32'h1);
        applyStimulus();
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h1111;
        link_en = 1'b1; link_data = 16'h3002; rd_addr_a = 3'd1; rd_addr_b = 3'd7;
        push_expect("dual_byp_r1", 0, 0, 32'h1111);
        push_expect("dual_byp_r7", 0, 1, 32'h3002);
        push_expect("dual_nb_r1_old", 1, 0, 32'h0);
        push_expect("dual_nb_r7_old", 1, 1, 32'h3001);
        applyStimulus();
        rd_addr_a = 3'd1; rd_addr_b = 3'd7;
        push_expect("dual_r1", 0, 0, 32'h1111);
        push_expect("dual_r7", 0, 1, 32'h3002);
        push_expect("dual_r1_nb", 1, 0, 32'h1111);
        push_expect("dual_r7_nb", 1, 1, 32'h3002);

        // Scoreboard set, repeated set, clear and set-over-clear.
        applyStimulus();
        sb_set = 1'b1; sb_addr = 3'd4; rd_addr_b = 3'd4;
        push_expect("sb_set_no_comb_stall", 0, 5, 32'h0);
        applyStimulus();
        rd_addr_b = 3'd4;
        push_expect("sb_pending", 0, 5, 32'h1);
        push_expect("sb_pending_nb", 1, 5, 32'h1);
        applyStimulus();
        sb_set = 1'b1; sb_addr = 3'd4; rd_addr_b = 3'd4;
        push_expect("sb_pending_again", 0, 5, 32'h1);
        applyStimulus();
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h00AA; rd_addr_b = 3'd4;
        push_expect("sb_wr_release", 0, 5, 32'h0);
        push_expect("sb_wr_data", 0, 1, 32'h00AA);
        push_expect("sb_wr_hold_nb", 1, 5, 32'h1);
        push_expect("sb_wr_old_nb", 1, 1, 32'h0);
        applyStimulus();
        rd_addr_b = 3'd4;
        push_expect("sb_clear", 0, 5, 32'h0);
        push_expect("sb_clear_nb", 1, 5, 32'h0);
        push_expect("sb_data_nb", 1, 1, 32'h00AA);
        applyStimulus();
        sb_set = 1'b1; sb_addr = 3'd4;
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h00BB; rd_addr_b = 3'd4;
        push_expect("sb_setclr_now", 0, 5, 32'h0);
        push_expect("sb_setclr_data", 0, 1, 32'h00BB);
        applyStimulus();
        rd_addr_b = 3'd4;
        push_expect("sb_set_wins", 0, 5, 32'h1);
        push_expect("sb_set_wins_nb", 1, 5, 32'h1);
        push_expect("sb_setclr_r4", 0, 1, 32'h00BB);
        applyStimulus();
        sb_set = 1'b1; sb_addr = 3'd7;
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h00CC;
        rd_addr_a = 3'd7; rd_addr_b = 3'd4;
        push_expect("sb7_not_yet", 0, 4, 32'h0);
        push_expect("sb4_release", 0, 5, 32'h0);
        push_expect("sb4_hold_nb", 1, 5, 32'h1);
        applyStimulus();
        rd_addr_a = 3'd7; rd_addr_b = 3'd4;
        push_expect("sb7_pending", 0, 4, 32'h1);
        push_expect("sb7_pending_nb", 1, 4, 32'h1);
        push_expect("sb4_cleared", 0, 5, 32'h0);
        push_expect("sb4_cleared_nb", 1, 5, 32'h0);
        applyStimulus();
        link_en = 1'b1; link_data = 16'h3003; rd_addr_a = 3'd7;
        push_expect("sb7_link_release", 0, 4, 32'h0);
        push_expect("sb7_link_data", 0, 0, 32'h3003);
        push_expect("sb7_link_hold_nb", 1, 4, 32'h1);
        push_expect("sb7_link_old_nb", 1, 0, 32'h3002);
        applyStimulus();
        rd_addr_a = 3'd7;
        push_expect("sb7_cleared", 0, 4, 32'h0);
        push_expect("sb7_cleared_nb", 1, 4, 32'h0);
        push_expect("sb7_data_nb", 1, 0, 32'h3003);

        // 32-bit instance with 6 registers: addresses 6 and 7 do not exist.
        applyStimulus();
        p_wr_en = 1'b1; p_wr_addr = 3'd7; p_wr_data = 32'hDEADBEEF;
        p_sb_set = 1'b1; p_sb_addr = 3'd7; p_rd_addr_a = 3'd7;
        push_expect("p_oor_read_byp", 2, 0, 32'h0);
        applyStimulus();
        p_rd_addr_a = 3'd7; p_rd_addr_b = 3'd1;
        push_expect("p_oor_read", 2, 0, 32'h0);
        push_expect("p_oor_stall", 2, 4, 32'h0);
        push_expect("p_no_alias", 2, 1, 32'h0);
        applyStimulus();
        p_cc_en = 1'b1; p_wr_en = 1'b1; p_wr_addr = 3'd3;
        p_wr_data = 32'h80000000; p_link_en = 1'b1; p_link_data = 32'h0000ABCD;
        applyStimulus();
        p_rd_addr_a = 3'd3; p_rd_addr_b = 3'd5;
        push_expect("p_cc_neg", 2, 2, 32'h4);
        push_expect("p_r3", 2, 0, 32'h80000000);
        push_expect("p_link_r5", 2, 1, 32'h0000ABCD);
        applyStimulus();
        p_sb_set = 1'b1; p_sb_addr = 3'd5;
        applyStimulus();
        p_rd_addr_a = 3'd5;
        push_expect("p_sb_pending", 2, 4, 32'h1);

        applyStimulus();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain pending=%0d required=0", exp_q.size());
        end
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lc3_regfile_sb.md
Name: lc3_regfile_sb

Overview:
- Parametrised successor to the LC-3 datapath register file, for the pipelined core.
- Provides a NUM_REGS x DATA_W register array with two combinational read ports and one general write port.
- Adds a dedicated link-register write port, optional write-to-read bypass, and an NZP condition-code register with explicit load control.
- Adds branch-condition evaluation and a per-register pending-write scoreboard that generates read stalls for multi-cycle (load) results.

Parameters:
- DATA_W, 16, register and data width in bits (>= 2).
- NUM_REGS, 8, number of architectural registers (>= 2; need not be a power of 2).
- LINK_REG, 7, index written by the link port (< NUM_REGS).
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads see array only.
- AW, $clog2(NUM_REGS), address width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- rd_addr_a  in  AW  read port A address.
- rd_addr_b  in  AW  read port B address.
- rd_data_a  out  DATA_W  read port A data.
- rd_data_b  out  DATA_W  read port B data.
- wr_en  in  1  general write enable.
- wr_addr  in  AW  general write address.
- wr_data  in  DATA_W  general write data; also the condition-code source.
- link_en  in  1  link write enable (JSR/JSRR/TRAP).
- link_data  in  DATA_W  return address written to LINK_REG.
- cc_en  in  1  load NZP from wr_data this edge.
- nzp  out  3  current condition codes {N,Z,P}.
- br_nzp  in  3  branch mask {n,z,p} from the instruction.
- br_taken  out  1  branch condition true.
- sb_set  in  1  mark register pending (long-latency op issued).
- sb_addr  in  AW  register to mark pending.
- stall_a  out  1  port A source pending.
- stall_b  out  1  port B source pending.

Behaviour:
- Reset (rst_n low, asynchronous): all registers = 0; nzp = 3'b010; all pending bits = 0. Outputs follow combinationally: rd_data = 0 unless bypassing, br_taken = br_nzp[1].
- Reset asserted mid-operation discards any in-flight write, set, or cc load. The first posedge after rst_n rises behaves normally.
- Write: at posedge, if wr_en and wr_addr < NUM_REGS, reg[wr_addr] <= wr_data. If link_en, reg[LINK_REG] <= link_data.
- Write collision: if wr_en and link_en both target LINK_REG, link_data wins and wr_data is dropped. Writes to different addresses both commit.
- Out-of-range address (>= NUM_REGS): writes are ignored, reads return 0, sb_set is ignored, stall = 0.
- Read: combinational from the array.
  - BYPASS=1: rd_data_x = link_data if link_en and rd_addr_x == LINK_REG; else wr_data if wr_en and wr_addr == rd_addr_x; else the array value. Zero added latency.
  - BYPASS=0: new data is visible the cycle after the write edge.
- Condition codes: at posedge, if cc_en: N <= wr_data[DATA_W-1]; Z <= (wr_data == 0); P <= !N && !Z. Exactly one bit is always set.
  - cc_en is independent of wr_en and wr_addr: a link write does not touch the codes.
  - If cc_en is low, nzp holds its value.
- Branch: br_taken = |(br_nzp & nzp). Uses registered nzp, i.e. codes from earlier edges, never same-cycle wr_data. br_nzp = 000 gives 0; br_nzp = 111 gives 1.
- Scoreboard: one pending bit per register.
  - sb_set sets pending[sb_addr] at posedge.
  - wr_en clears pending[wr_addr]; link_en clears pending[LINK_REG].
  - Simultaneous set and clear of the same register: set wins (new issue supersedes).
  - sb_set on an already-pending register: bit stays set, no error.
- Stall: stall_x = pending[rd_addr_x] && !(BYPASS && the write (wr or link) this cycle targets rd_addr_x). With BYPASS=0, stall persists through the write cycle and drops the cycle after.
- No internal FSM beyond the pending-bit and nzp state; all outputs are combinational from state and inputs. No combinational path runs from rd_addr to stall through sb_set.

Test Plan:
- Reset: rst_n=0 mid-write of R3=16'h1234 -> after release, R3 reads 0, nzp=010, stall_a=stall_b=0, br_taken=1 with br_nzp=010.
- Write/bypass: BYPASS=1, wr_en R2=16'hBEEF with rd_addr_a=2 in the same cycle -> rd_data_a=16'hBEEF that cycle. BYPASS=0 -> old value that cycle, BEEF the next.
- Condition codes: cc_en with wr_data=16'h8000 -> nzp=100; with 0 -> 010; with 16'h0001 -> 001. Then br_nzp=011 -> br_taken=0, 1, 1 respectively, each one cycle after the load.
- Link collision: wr_en R7=16'h1111 and link_en link_data=16'h3001 on the same edge -> R7=16'h3001. Same with wr_addr=R1 -> R1=16'h1111 and R7=16'h3001.
- Scoreboard: sb_set R4, then rd_addr_b=4 -> stall_b=1 until wr_en R4=16'h00AA. That cycle stall_b=0 with rd_data_b=16'h00AA (BYPASS=1). Simultaneous sb_set R4 and wr_en R4 -> pending stays 1.
- Parametrisation: DATA_W=32, NUM_REGS=6, LINK_REG=5 -> write to address 7 ignored and reads 0; cc on 32'h80000000 gives nzp=100.
